execute_mc: RTL and testbench

//  Parametrised, handshaked execute stage with an integrated EX/MEM output register.

---
 rtl/execute_pkg.sv | 36 +++
 rtl/execute_mc_iter_mul.sv | 66 ++++++
 rtl/execute_mc.sv | 265 ++++++++++++++++++++++++++
 tb/tb_execute_mc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared opcodes, flag layout, forward-select codes and FSM state for execute_mc.
// Optional iterative multiplier is enabled with EXECUTE_MUL_EN.
package execute_pkg;

    localparam int OPC_W = 4;
    typedef logic [OPC_W-1:0] op_t;

    localparam op_t OP_ADD   = 4'd0;
    localparam op_t OP_SUB   = 4'd1;
    localparam op_t OP_AND   = 4'd2;
    localparam op_t OP_OR    = 4'd3;
    localparam op_t OP_XOR   = 4'd4;
    localparam op_t OP_SLL   = 4'd5;
    localparam op_t OP_SRL   = 4'd6;
    localparam op_t OP_SRA   = 4'd7;
    localparam op_t OP_SLT   = 4'd8;
    localparam op_t OP_PASSB = 4'd9;
    localparam op_t OP_MUL   = 4'd10;

    // One bit per opcode: ADD SUB AND OR XOR MUL update flags
    localparam logic [2**OPC_W-1:0] FLAG_MASK = 16'h041F;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_RUN
    } state_t;

endpackage

// File: rtl/execute_mc_iter_mul.sv
// Shift-add unsigned multiplier retiring BPC multiplier bits per step.
// Used by execute_mc only when EXECUTE_MUL_EN is defined.
module iter_mul
    import execute_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BPC    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_step,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_prod
);

    localparam int STEPS = DATA_W / BPC;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    logic                 r_run;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*DATA_W-1:0]  r_acc;
    logic [2*DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]    r_b;
    logic [2*DATA_W-1:0]  w_part;
    logic [2*DATA_W-1:0]  w_acc_nx;

    always_comb begin
        w_part = '0;
        for (int k = 0; k < BPC; k++) begin
            if (r_b[k]) w_part = w_part + (r_a << k);
        end
        w_acc_nx = r_acc + w_part;
    end

    // Product is presented combinationally so the last step's edge can retire it
    assign o_done = r_run && (r_cnt == LAST);
    assign o_prod = w_acc_nx;

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
            r_acc <= '0;
            r_a   <= {{DATA_W{1'b0}}, i_a};
            r_b   <= i_b;
        end else if (r_run && i_step) begin
            r_acc <= w_acc_nx;
            r_a   <= r_a << BPC;
            r_b   <= r_b >> BPC;
            if (o_done) r_run <= 1'b0;
            else        r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/execute_mc.sv
// Handshaked execute stage with 3-way forwarding and EX/MEM output register.
// Define EXECUTE_MUL_EN to include the iterative multiplier (MUL_RUN state).
module execute_mc
    import execute_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int OP_W    = 4,
    parameter int CTRL_W  = 5,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_in,
    input  logic              alu_src_in,
    input  logic [DATA_W-1:0] a_data_in,
    input  logic [DATA_W-1:0] b_data_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rs1_in,
    input  logic [REG_W-1:0]  rs2_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [1:0]        fwd_sel_a,
    input  logic [1:0]        fwd_sel_b,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] store_out,
    output logic [REG_W-1:0]  rs1_out,
    output logic [REG_W-1:0]  rs2_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [2:0]        flags_out,
    output logic              busy
);

`ifdef EXECUTE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam int SH_W = $clog2(DATA_W);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_valid;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_store;
    logic [REG_W-1:0]    r_rs1;
    logic [REG_W-1:0]    r_rs2;
    logic [REG_W-1:0]    r_rd;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [2:0]          r_flags;
    logic [DATA_W-1:0]   r_p_store;
    logic [REG_W-1:0]    r_p_rs1;
    logic [REG_W-1:0]    r_p_rs2;
    logic [REG_W-1:0]    r_p_rd;
    logic [CTRL_W-1:0]   r_p_ctrl;

    op_t                 w_op;
    logic                w_free;
    logic                w_accept;
    logic                w_is_mul;
    logic                w_load_alu;
    logic                w_mul_start;
    logic                w_mul_done;
    logic                w_m_done;
    logic                w_flag_upd;
    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_rs2f;
    logic [DATA_W-1:0]   w_op_b;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_alu;
    logic                w_alu_v;
    logic [SH_W-1:0]     w_sh;
    logic [2:0]          w_alu_flags;
    logic [2:0]          w_mul_flags;
    logic [DATA_W-1:0]   w_mul_lo;
    logic [2*DATA_W-1:0] w_prod;

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] wb
    );
        case (sel)
            FWD_MEM: fwd_mux = mem;
            FWD_WB:  fwd_mux = wb;
            default: fwd_mux = rf;
        endcase
    endfunction

    assign w_op   = op_t'(op_in);
    assign w_op_a = fwd_mux(fwd_sel_a, a_data_in, fwd_mem_data, fwd_wb_data);
    assign w_rs2f = fwd_mux(fwd_sel_b, b_data_in, fwd_mem_data, fwd_wb_data);
    assign w_op_b = alu_src_in ? imm_in : w_rs2f;
    assign w_sum  = w_op_a + w_op_b;
    assign w_diff = w_op_a - w_op_b;
    assign w_sh   = w_op_b[SH_W-1:0];

    assign w_free      = !r_valid || out_ready;
    assign in_ready    = !rst && (r_state == ST_IDLE) && w_free;
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (w_op == OP_MUL);
    assign w_load_alu  = w_accept && !flush && !(MUL_EN && w_is_mul);
    assign w_mul_start = w_accept && !flush && MUL_EN && w_is_mul;
    assign w_mul_done  = (r_state == ST_MUL_RUN) && w_m_done && w_free;
    // A disabled MUL retires through the ALU path with flags left alone
    assign w_flag_upd  = FLAG_MASK[w_op] && !w_is_mul;

    always_comb begin
        w_alu   = '0;
        w_alu_v = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_alu   = w_sum;
                w_alu_v = (w_op_a[DATA_W-1] == w_op_b[DATA_W-1])
                       && (w_sum[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            OP_SUB: begin
                w_alu   = w_diff;
                w_alu_v = (w_op_a[DATA_W-1] != w_op_b[DATA_W-1])
                       && (w_diff[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            OP_AND:   w_alu = w_op_a & w_op_b;
            OP_OR:    w_alu = w_op_a | w_op_b;
            OP_XOR:   w_alu = w_op_a ^ w_op_b;
            OP_SLL:   w_alu = w_op_a << w_sh;
            OP_SRL:   w_alu = w_op_a >> w_sh;
            OP_SRA:   w_alu = $signed(w_op_a) >>> w_sh;
            OP_SLT:   w_alu = {{(DATA_W-1){1'b0}},
                               $signed(w_op_a) < $signed(w_op_b)};
            OP_PASSB: w_alu = w_op_b;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_alu_flags        = '0;
        w_alu_flags[FLG_Z] = (w_alu == '0);
        w_alu_flags[FLG_V] = w_alu_v;
        w_alu_flags[FLG_N] = w_alu[DATA_W-1];
    end

    assign w_mul_lo = w_prod[DATA_W-1:0];

    always_comb begin
        w_mul_flags        = '0;
        w_mul_flags[FLG_Z] = (w_mul_lo == '0);
        w_mul_flags[FLG_V] = |w_prod[2*DATA_W-1:DATA_W];
        w_mul_flags[FLG_N] = w_mul_lo[DATA_W-1];
    end

`ifdef EXECUTE_MUL_EN
    logic w_mul_step;

    // Freeze on the last step while the output register is still occupied
    assign w_mul_step = (r_state == ST_MUL_RUN) && !(w_m_done && !w_free);
    assign busy       = (r_state == ST_MUL_RUN);

    iter_mul #(
        .DATA_W (DATA_W),
        .BPC    (MUL_BPC)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_start),
        .i_abort (flush),
        .i_step  (w_mul_step),
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .o_done  (w_m_done),
        .o_prod  (w_prod)
    );
`else
    assign w_m_done = 1'b0;
    assign w_prod   = '0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_mul_start) w_state_nx = ST_MUL_RUN;
            end
            ST_MUL_RUN: begin
                if (flush || w_mul_done) w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_store   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_ctrl    <= '0;
            r_flags   <= '0;
            r_p_store <= '0;
            r_p_rs1   <= '0;
            r_p_rs2   <= '0;
            r_p_rd    <= '0;
            r_p_ctrl  <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load_alu) begin
                r_valid  <= 1'b1;
                r_result <= w_alu;
                r_store  <= w_rs2f;
                r_rs1    <= rs1_in;
                r_rs2    <= rs2_in;
                r_rd     <= rd_in;
                r_ctrl   <= ctrl_in;
                if (w_flag_upd) r_flags <= w_alu_flags;
            end else if (w_mul_done) begin
                r_valid  <= 1'b1;
                r_result <= w_mul_lo;
                r_store  <= r_p_store;
                r_rs1    <= r_p_rs1;
                r_rs2    <= r_p_rs2;
                r_rd     <= r_p_rd;
                r_ctrl   <= r_p_ctrl;
                if (FLAG_MASK[OP_MUL]) r_flags <= w_mul_flags;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            // Side-band fields wait here until the multiply retires
            if (w_mul_start) begin
                r_p_store <= w_rs2f;
                r_p_rs1   <= rs1_in;
                r_p_rs2   <= rs2_in;
                r_p_rd    <= rd_in;
                r_p_ctrl  <= ctrl_in;
            end
        end
    end

    assign out_valid  = r_valid;
    assign result_out = r_result;
    assign store_out  = r_store;
    assign rs1_out    = r_rs1;
    assign rs2_out    = r_rs2;
    assign rd_out     = r_rd;
    assign ctrl_out   = r_ctrl;
    assign flags_out  = r_flags;

endmodule

// File: tb/tb_execute_mc.sv
// Randomized bench for execute_mc against a transaction-level model.
// Follows EXECUTE_MUL_EN so the same bench covers both builds.
module tb_execute_mc;
    import execute_pkg::*;

`ifdef EXECUTE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_in;
    logic        alu_src_in;
    logic [15:0] a_data_in, b_data_in, imm_in;
    logic [3:0]  rs1_in, rs2_in, rd_in;
    logic [4:0]  ctrl_in;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [15:0] fwd_mem_data, fwd_wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_out, store_out;
    logic [3:0]  rs1_out, rs2_out, rd_out;
    logic [4:0]  ctrl_out;
    logic [2:0]  flags_out;
    logic        busy;

    execute_mc #(
        .DATA_W(16), .REG_W(4), .OP_W(4), .CTRL_W(5), .MUL_BPC(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_in(op_in), .alu_src_in(alu_src_in),
        .a_data_in(a_data_in), .b_data_in(b_data_in), .imm_in(imm_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result_out(result_out), .store_out(store_out),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .ctrl_out(ctrl_out), .flags_out(flags_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the EX/MEM register and an in-flight multiply
    logic        m_valid;
    logic [15:0] m_res, m_store;
    logic [3:0]  m_rs1, m_rs2, m_rd;
    logic [4:0]  m_ctrl;
    logic [2:0]  m_flags;
    int          m_left;
    logic [31:0] p_prod;
    logic [15:0] p_store;
    logic [3:0]  p_rs1, p_rs2, p_rd;
    logic [4:0]  p_ctrl;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fwd(input logic [1:0] sel,
                                        input logic [15:0] rf);
        if (sel == 2'b01)      return fwd_mem_data;
        else if (sel == 2'b10) return fwd_wb_data;
        else                   return rf;
    endfunction

    function automatic void ref_alu(input logic [3:0] op,
        input logic [15:0] a, input logic [15:0] b,
        output logic [15:0] r, output logic v, output logic upd);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = '0; v = 1'b0; upd = 1'b0;
        case (op)
            OP_ADD: begin
                s = sa + sb; r = 16'(s);
                v = (s > 32767) || (s < -32768); upd = 1'b1;
            end
            OP_SUB: begin
                s = sa - sb; r = 16'(s);
                v = (s > 32767) || (s < -32768); upd = 1'b1;
            end
            OP_AND:   begin r = a & b; upd = 1'b1; end
            OP_OR:    begin r = a | b; upd = 1'b1; end
            OP_XOR:   begin r = a ^ b; upd = 1'b1; end
            OP_SLL:   r = a << b[3:0];
            OP_SRL:   r = a >> b[3:0];
            OP_SRA:   r = 16'($signed(a) >>> b[3:0]);
            OP_SLT:   r = (sa < sb) ? 16'd1 : 16'd0;
            OP_PASSB: r = b;
            default:  ;
        endcase
    endfunction

    function automatic logic exp_rdy();
        return !rst && (m_left == 0) && (!m_valid || out_ready);
    endfunction

    task automatic model_step();
        logic        acc, free, done, v, upd, is_mul;
        logic [15:0] a, rs2f, b, r, lo;
        acc    = in_valid && exp_rdy();
        is_mul = MUL_EN && (op_in == OP_MUL);
        a      = fwd(fwd_sel_a, a_data_in);
        rs2f   = fwd(fwd_sel_b, b_data_in);
        b      = alu_src_in ? imm_in : rs2f;
        if (rst) begin
            m_valid = 0; m_res = 0; m_store = 0; m_rs1 = 0; m_rs2 = 0;
            m_rd = 0; m_ctrl = 0; m_flags = 0; m_left = 0;
        end else if (flush) begin
            m_valid = 0;
            m_left  = 0;
        end else begin
            free = !m_valid || out_ready;
            done = (m_left == 1) && free;
            if (acc && !is_mul) begin
                ref_alu(op_in, a, b, r, v, upd);
                m_valid = 1; m_res = r; m_store = rs2f;
                m_rs1 = rs1_in; m_rs2 = rs2_in; m_rd = rd_in; m_ctrl = ctrl_in;
                if (upd) m_flags = {r == 16'd0, v, r[15]};
            end else if (done) begin
                lo = p_prod[15:0];
                m_valid = 1; m_res = lo; m_store = p_store;
                m_rs1 = p_rs1; m_rs2 = p_rs2; m_rd = p_rd; m_ctrl = p_ctrl;
                m_flags = {lo == 16'd0, p_prod[31:16] != 16'd0, lo[15]};
                m_left = 0;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (acc && is_mul) begin
                m_left  = MUL_CYC;
                p_prod  = 32'(a) * 32'(b);
                p_store = rs2f; p_rs1 = rs1_in; p_rs2 = rs2_in;
                p_rd = rd_in; p_ctrl = ctrl_in;
            end else if (m_left > 1) begin
                m_left--;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("flags", 32'(flags_out), 32'(m_flags));
        if (m_valid) begin
            chk("result", 32'(result_out), 32'(m_res));
            chk("store", 32'(store_out), 32'(m_store));
            chk("regs", {20'd0, rs1_out, rs2_out, rd_out},
                        {20'd0, m_rs1, m_rs2, m_rd});
            chk("ctrl", 32'(ctrl_out), 32'(m_ctrl));
        end
    endtask

    // Inputs are already driven; check ready, advance model, clock once
    task automatic tick();
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy()));
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        in_valid = 1; op_in = op; alu_src_in = 0;
        a_data_in = a; b_data_in = b;
        fwd_sel_a = 2'b00; fwd_sel_b = 2'b00;
        rs1_in = 4'd1; rs2_in = 4'd2; rd_in = 4'd3; ctrl_in = 5'b00100;
    endtask

    function automatic logic [15:0] rnd16();
        logic [15:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'h7FFF;
        corner[2] = 16'h8000; corner[3] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        int n;
        rst = 1; in_valid = 0; op_in = 0; alu_src_in = 0;
        a_data_in = 0; b_data_in = 0; imm_in = 0;
        rs1_in = 0; rs2_in = 0; rd_in = 0; ctrl_in = 0;
        fwd_sel_a = 0; fwd_sel_b = 0; fwd_mem_data = 0; fwd_wb_data = 0;
        flush = 0; out_ready = 1;
        m_valid = 0; m_res = 0; m_store = 0; m_rs1 = 0; m_rs2 = 0;
        m_rd = 0; m_ctrl = 0; m_flags = 0; m_left = 0;
        p_prod = 0; p_store = 0; p_rs1 = 0; p_rs2 = 0; p_rd = 0; p_ctrl = 0;

        @(negedge clk);
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result_out), 32'd0);
        chk("rst_flags", 32'(flags_out), 32'd0);
        rst = 0;

        issue(OP_ADD, 16'h7FFF, 16'h0001);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", 32'(result_out), 32'h8000);
        chk("add_flags", 32'(flags_out), 32'b011);

        issue(OP_SUB, 16'hAAAA, 16'h5555);
        fwd_sel_a = 2'b01; fwd_mem_data = 16'h0010;
        fwd_sel_b = 2'b10; fwd_wb_data  = 16'h0003;
        tick();
        chk("sub_result", 32'(result_out), 32'h000D);
        chk("sub_store", 32'(store_out), 32'h0003);

        in_valid = 0; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_rdy", 32'(in_ready), 32'd0);
            tick();
        end
        chk("stall_hold", 32'(result_out), 32'h000D);
        issue(OP_ADD, 16'h0005, 16'h0006);
        out_ready = 1;
        #1 chk("release_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("release_result", 32'(result_out), 32'h000B);

        issue(OP_MUL, 16'h0100, 16'h0101);
        tick();
        in_valid = 0;
        if (MUL_EN) begin
            n = 0;
            while (busy && n < 40) begin
                n++;
                tick();
            end
            chk("mul_busy_cycles", 32'(n), 32'd16);
            chk("mul_valid", 32'(out_valid), 32'd1);
            chk("mul_result", 32'(result_out), 32'h0100);
            chk("mul_flags", 32'(flags_out), 32'b010);
            tick();

            issue(OP_MUL, 16'h1234, 16'h0FF0);
            tick();
            in_valid = 0;
            for (int i = 0; i < 4; i++) tick();
            flush = 1;
            tick();
            flush = 0;
            chk("flush_busy", 32'(busy), 32'd0);
            chk("flush_valid", 32'(out_valid), 32'd0);
            chk("flush_flags", 32'(flags_out), 32'b010);
            #1 chk("flush_rdy", 32'(in_ready), 32'd1);
        end else begin
            chk("mul_off_valid", 32'(out_valid), 32'd1);
            chk("mul_off_result", 32'(result_out), 32'h0000);
            chk("mul_off_flags", 32'(flags_out), 32'b000);
        end

        issue(OP_MUL, 16'h00FF, 16'h00FF);
        tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rstmul_valid", 32'(out_valid), 32'd0);
        chk("rstmul_busy", 32'(busy), 32'd0);
        chk("rstmul_result", 32'(result_out), 32'd0);
        chk("rstmul_store", 32'(store_out), 32'd0);
        chk("rstmul_flags", 32'(flags_out), 32'd0);
        chk("rstmul_ctrl", 32'(ctrl_out), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            flush        = ($urandom_range(0, 39) == 0);
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 9) < 7);
            op_in        = 4'($urandom_range(0, 15));
            alu_src_in   = 1'($urandom);
            a_data_in    = rnd16();
            b_data_in    = rnd16();
            imm_in       = rnd16();
            rs1_in       = 4'($urandom);
            rs2_in       = 4'($urandom);
            rd_in        = 4'($urandom);
            ctrl_in      = 5'($urandom);
            fwd_sel_a    = 2'($urandom);
            fwd_sel_b    = 2'($urandom);
            fwd_mem_data = rnd16();
            fwd_wb_data  = rnd16();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
